// File: rtl/fixed_point_addsub_pipe_if.sv
// Streaming operand/result bundle for the fixed-point add/subtract pipe.
// The unit takes the slave view and the producer/consumer takes the master view.
interface fixed_point_addsub_pipe_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         ovf;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, ovf
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, ovf
  );
endinterface

// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage sign-magnitude fixed-point add/subtract with valid/ready flow
// control, saturation on magnitude overflow and a saturating overflow counter.
// Stage 1 latches decoded signs, magnitudes and the magnitude compare;
// stage 2 latches the final result. Both stages advance together.
module fixed_point_addsub_pipe #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fixed_point_addsub_pipe_if.slave bus,
  output logic [CNT_W-1:0]     ovf_count
);
  localparam int MW = N - 1;  // magnitude width

  // Reject parameter sets the number format cannot represent.
  generate
    if (Q < 0 || Q > N - 2 || N < 4) begin : g_param_check
      $error("fixed_point_addsub_pipe: illegal Q/N combination");
    end
  endgenerate

  logic          adv;

  logic          s1_valid_reg;
  logic          s1_sa_reg;
  logic          s1_sb_reg;
  logic          s1_geq_reg;
  logic [MW-1:0] s1_ma_reg;
  logic [MW-1:0] s1_mb_reg;

  logic          out_valid_reg;
  logic          ovf_reg;
  logic [N-1:0]  c_reg;
  logic [CNT_W-1:0] ovf_count_reg;

  logic [MW-1:0] in_ma;
  logic [MW-1:0] in_mb;
  logic          in_sa;
  logic          in_sb;

  logic [N-1:0]  sum;
  logic [MW-1:0] diff;
  logic [MW-1:0] mag;
  logic          sign;
  logic [N-1:0]  c_next;
  logic          ovf_next;

  // Both stages move only when the output stage is empty or being drained.
  assign adv          = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_reg;
  assign bus.c        = c_reg;
  assign bus.ovf      = ovf_reg;
  assign ovf_count    = ovf_count_reg;

  // Input decode: -0 collapses to +0, op folds into B's effective sign.
  always_comb begin
    in_ma = bus.a[MW-1:0];
    in_mb = bus.b[MW-1:0];
    in_sa = bus.a[N-1] & (|in_ma);
    in_sb = (bus.b[N-1] & (|in_mb)) ^ bus.op;
  end

  // Result formation from stage-1 contents; zero magnitude is always +0.
  always_comb begin
    sum      = {1'b0, s1_ma_reg} + {1'b0, s1_mb_reg};
    diff     = s1_geq_reg ? (s1_ma_reg - s1_mb_reg) : (s1_mb_reg - s1_ma_reg);
    mag      = '0;
    sign     = 1'b0;
    ovf_next = 1'b0;
    if (s1_sa_reg == s1_sb_reg) begin
      sign = s1_sa_reg;
      if (sum[N-1]) begin
        mag      = '1;
        ovf_next = 1'b1;
      end else begin
        mag = sum[MW-1:0];
      end
    end else begin
      mag  = diff;
      sign = s1_geq_reg ? s1_sa_reg : s1_sb_reg;
    end
    c_next = {sign & (|mag), mag};
  end

  // Pipeline registers; payload only loads alongside a valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sa_reg     <= 1'b0;
      s1_sb_reg     <= 1'b0;
      s1_geq_reg    <= 1'b0;
      s1_ma_reg     <= '0;
      s1_mb_reg     <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      c_reg         <= '0;
    end else if (adv) begin
      s1_valid_reg  <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sa_reg  <= in_sa;
        s1_sb_reg  <= in_sb;
        s1_ma_reg  <= in_ma;
        s1_mb_reg  <= in_mb;
        s1_geq_reg <= (in_ma >= in_mb);
      end
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        c_reg   <= c_next;
        ovf_reg <= ovf_next;
      end
    end
  end

  // Count delivered overflowed results, sticking at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count_reg <= '0;
    end else if (out_valid_reg && bus.out_ready && ovf_reg && (ovf_count_reg != '1)) begin
      ovf_count_reg <= ovf_count_reg + 1'b1;
    end
  end
endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Directed bench for fixed_point_addsub_pipe (N=32, Q=15). A second instance
// with CNT_W=2 mirrors the same stimulus to exercise counter saturation.
module tb_fixed_point_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ovf_count;
  logic [1:0] ovf_count2;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixed_point_addsub_pipe_if #(.N(32)) bus ();
  fixed_point_addsub_pipe_if #(.N(32)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.a         = bus.a;
  assign bus2.b         = bus.b;
  assign bus2.op        = bus.op;
  assign bus2.out_ready = bus.out_ready;

  fixed_point_addsub_pipe #(.Q(15), .N(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ovf_count(ovf_count)
  );

  fixed_point_addsub_pipe #(.Q(15), .N(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .ovf_count(ovf_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One unstalled transaction: accept, check 2-edge latency, result, counter.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic opv, input logic [31:0] exp_c, input logic exp_ovf,
                       input logic [31:0] exp_cnt);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.op = opv; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".lat1"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".lat2"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".c"}, bus.c, exp_c);
    chk({tag, ".ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    @(negedge clk);
    chk({tag, ".cnt"}, {24'd0, ovf_count}, exp_cnt);
    $display("txn %s a=%h b=%h op=%0d c=%h ovf=%0d cnt=%0d", tag, av, bv, opv, bus.c, bus.ovf, ovf_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.c", bus.c, 32'd0);
    chk("rst.ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst.cnt", {24'd0, ovf_count}, 32'd0);
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

    do_op("add",     32'h0000C000, 32'h00012000, 1'b0, 32'h0001E000, 1'b0, 32'd0);
    do_op("subflip", 32'h00008000, 32'h00018000, 1'b1, 32'h80010000, 1'b0, 32'd0);
    do_op("subzero", 32'h80008000, 32'h80008000, 1'b1, 32'h00000000, 1'b0, 32'd0);
    do_op("negzero", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 32'd0);
    do_op("cancel",  32'h00008000, 32'h80008000, 1'b0, 32'h00000000, 1'b0, 32'd0);
    do_op("satpos",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 32'd1);
    do_op("satneg",  32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 32'd2);
    chk("cnt2.after2", {30'd0, ovf_count2}, 32'd2);
    do_op("sat3", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 32'd3);
    chk("cnt2.after3", {30'd0, ovf_count2}, 32'd3);
    do_op("sat4", 32'hC0000000, 32'h40000000, 1'b1, 32'hFFFFFFFF, 1'b1, 32'd4);
    do_op("sat5", 32'h40000000, 32'h40000000, 1'b0, 32'h7FFFFFFF, 1'b1, 32'd5);
    chk("cnt2.sat", {30'd0, ovf_count2}, 32'd3);

    // Backpressure: three offers with consumer stalled; only two fit.
    @(negedge clk);
    bus.out_ready = 1'b0; bus.op = 1'b0; bus.in_valid = 1'b1;
    bus.a = 32'h00008000; bus.b = 32'h00008000;
    #1 chk("bp.acc0", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.a = 32'h00010000; bus.b = 32'h00010000;
    #1 chk("bp.acc1", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.a = 32'h00018000; bus.b = 32'h00018000;
    #1 chk("bp.full", {31'd0, bus.in_ready}, 32'd0);
    chk("bp.c_first", bus.c, 32'h00010000);
    @(negedge clk);
    chk("bp.hold_c", bus.c, 32'h00010000);
    chk("bp.hold_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.hold_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    #1 chk("bp.release_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("txn bp0 c=%h", bus.c);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.out1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.out1", bus.c, 32'h00020000);
    $display("txn bp1 c=%h", bus.c);
    @(negedge clk);
    chk("bp.out2_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.out2", bus.c, 32'h00030000);
    $display("txn bp2 c=%h", bus.c);
    @(negedge clk);
    chk("bp.drained", {31'd0, bus.out_valid}, 32'd0);

    // Reset with two in flight, one of them an overflow sitting at the output.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.op = 1'b0;
    bus.a = 32'h7FFFFFFF; bus.b = 32'h00000001;
    @(negedge clk);
    bus.a = 32'h00008000; bus.b = 32'h00008000;
    @(negedge clk);
    chk("rstmid.pre_ovf", {31'd0, bus.ovf}, 32'd1);
    rst = 1'b1; bus.out_ready = 1'b1; bus.a = 32'h00010000; bus.b = 32'h00010000;
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("rstmid.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rstmid.c", bus.c, 32'd0);
    chk("rstmid.ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rstmid.cnt", {24'd0, ovf_count}, 32'd0);
    chk("rstmid.in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("txn rstmid out_valid=%0d c=%h cnt=%0d", bus.out_valid, bus.c, ovf_count);
    @(negedge clk);
    chk("rstmid.nostale1", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("rstmid.nostale2", {31'd0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
